// File: rtl/ahb_bus_arbiter_pkg.sv
// rtl/ahb_bus_arbiter_pkg.sv - shared AHB transfer codes used by the bus arbiter
//
// Purpose: AHB HTRANS/HBURST encodings and widths shared by the arbiter and its users.
// Ports:   none (package).
package ahb_bus_arbiter_pkg;

  localparam int W_BURST = 3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [W_BURST-1:0] HBURST_SINGLE = '0;

  // hold_cnt saturation value
  localparam logic [7:0] HOLD_CNT_SAT = 8'hFF;

endpackage

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// rtl/ahb_bus_arbiter_rr_pick.sv - combinational round-robin request picker
//
// Purpose: returns the first requester found scanning last+1, last+2, ... mod N_MST.
// Ports:
//   req        in   N_MST  request vector
//   last       in   2      index of the most recent winner
//   win_idx    out  2      selected requester index (0 when none)
//   win_valid  out  1      at least one request present
module ahb_bus_arbiter_rr_pick #(
  parameter int N_MST = 2
) (
  input  logic [N_MST-1:0] req,
  input  logic [1:0]       last,
  output logic [1:0]       win_idx,
  output logic             win_valid
);

  logic [3:0] req_pad;
  logic [2:0] cand;
  logic [1:0] idx;

  // Scan from the farthest offset back to the nearest so the nearest
  // requester after 'last' is the final assignment.
  always_comb begin
    req_pad   = 4'(req);
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    idx       = '0;
    for (int k = N_MST; k >= 1; k--) begin
      cand = {1'b0, last} + 3'(k);
      if (cand >= 3'(N_MST)) begin
        cand = cand - 3'(N_MST);
      end
      idx = cand[1:0];
      if (req_pad[idx]) begin
        win_idx   = idx;
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - round-robin AHB arbiter sharing one slave bus among N_MST masters
//
// Purpose: grants one master at a time at transfer boundaries, never splits a burst,
//          muxes address/control by the address-phase owner and HWDATA by the
//          data-phase owner, and broadcasts the slave response.
// Ports:
//   HCLK, HRESET                         clock, synchronous active-high reset
//   i_HBUSREQ [N_MST]                    per-master bus request
//   i_HADDR/i_HTRANS/i_HWRITE/i_HSIZE/i_HBURST/i_HWDATA   packed master buses
//   o_HGRANT [N_MST], o_HMASTER [2]      address-phase owner (one-hot / index)
//   o_HADDR/o_HTRANS/o_HWRITE/o_HSIZE/o_HBURST            owner's address phase
//   o_HWDATA [32]                        data-phase owner's write data
//   i_HRDATA/i_HRESP/i_HREADY            slave response in
//   o_HRDATA/o_HRESP/o_HREADY            slave response broadcast to masters
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int N_MST    = 2,
  parameter int PARK_MST = 0,
  parameter int MAX_HOLD = 8
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [N_MST-1:0]         i_HBUSREQ,
  input  logic [N_MST*32-1:0]      i_HADDR,
  input  logic [N_MST*2-1:0]       i_HTRANS,
  input  logic [N_MST-1:0]         i_HWRITE,
  input  logic [N_MST*3-1:0]       i_HSIZE,
  input  logic [N_MST*W_BURST-1:0] i_HBURST,
  input  logic [N_MST*32-1:0]      i_HWDATA,
  output logic [N_MST-1:0]         o_HGRANT,
  output logic [1:0]               o_HMASTER,
  output logic [31:0]              o_HADDR,
  output logic [1:0]               o_HTRANS,
  output logic                     o_HWRITE,
  output logic [2:0]               o_HSIZE,
  output logic [W_BURST-1:0]       o_HBURST,
  output logic [31:0]              o_HWDATA,
  input  logic [31:0]              i_HRDATA,
  input  logic [1:0]               i_HRESP,
  input  logic                     i_HREADY,
  output logic [31:0]              o_HRDATA,
  output logic [1:0]               o_HRESP,
  output logic                     o_HREADY
);

  typedef enum logic [1:0] {
    ST_PARK  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam logic [1:0] PARK_IDX = 2'(PARK_MST);
  localparam logic [1:0] LAST_RST = 2'(N_MST - 1);

  state_t     state_q, state_d;
  logic [1:0] r_own_q, r_own_d;
  logic [1:0] r_down_q, r_down_d;
  logic [1:0] r_last_q, r_last_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic [N_MST-1:0] own_mask;
  logic [N_MST-1:0] pick_req;
  logic [1:0]       mux_trans;
  logic [1:0]       pick_idx;
  logic             pick_valid;
  logic [1:0]       winner;
  logic             others_req;
  logic             nonseq_acc;
  logic             burst_start;
  logic             boundary;

  // Owner muxes: address phase follows r_own, write data follows r_down.
  always_comb begin
    own_mask  = '0;
    o_HADDR   = '0;
    mux_trans = HTRANS_IDLE;
    o_HWRITE  = 1'b0;
    o_HSIZE   = '0;
    o_HBURST  = HBURST_SINGLE;
    o_HWDATA  = '0;
    for (int m = 0; m < N_MST; m++) begin
      if (r_own_q == 2'(m)) begin
        own_mask[m] = 1'b1;
        o_HADDR     = i_HADDR[32*m +: 32];
        mux_trans   = i_HTRANS[2*m +: 2];
        o_HWRITE    = i_HWRITE[m];
        o_HSIZE     = i_HSIZE[3*m +: 3];
        o_HBURST    = i_HBURST[W_BURST*m +: W_BURST];
      end
      if (r_down_q == 2'(m)) begin
        o_HWDATA = i_HWDATA[32*m +: 32];
      end
    end
  end

  // A parked owner did not ask for the bus, so its HTRANS is not trusted.
  assign o_HTRANS  = (state_q == ST_PARK) ? HTRANS_IDLE : mux_trans;
  assign o_HGRANT  = own_mask;
  assign o_HMASTER = r_own_q;
  assign o_HRDATA  = i_HRDATA;
  assign o_HRESP   = i_HRESP;
  assign o_HREADY  = i_HREADY;

  // An owner that has used up its hold budget drops out of the scan
  // whenever someone else is waiting.
  always_comb begin
    others_req = |(i_HBUSREQ & ~own_mask);
    pick_req   = i_HBUSREQ;
    if ((hold_cnt_q >= 8'(MAX_HOLD)) && others_req) begin
      pick_req = i_HBUSREQ & ~own_mask;
    end
  end

  ahb_bus_arbiter_rr_pick #(
    .N_MST (N_MST)
  ) u_rr_pick (
    .req       (pick_req),
    .last      (r_last_q),
    .win_idx   (pick_idx),
    .win_valid (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    r_own_d    = r_own_q;
    r_down_d   = r_down_q;
    r_last_d   = r_last_q;
    hold_cnt_d = hold_cnt_q;

    winner      = pick_valid ? pick_idx : PARK_IDX;
    nonseq_acc  = i_HREADY && (o_HTRANS == HTRANS_NONSEQ);
    burst_start = nonseq_acc && (o_HBURST != HBURST_SINGLE);
    // The edge accepting a burst's first NONSEQ already belongs to the
    // burst, so ownership must not move on it.
    boundary    = i_HREADY && (state_q != ST_BURST) && !burst_start;

    if (i_HREADY) begin
      r_down_d = r_own_q;
    end

    if (boundary) begin
      r_own_d = winner;
      if (pick_valid) begin
        r_last_d = winner;
      end
    end

    if (r_own_d != r_own_q) begin
      hold_cnt_d = '0;
    end else if (nonseq_acc && (hold_cnt_q != HOLD_CNT_SAT)) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end

    case (state_q)
      ST_PARK: begin
        if (boundary && pick_valid) begin
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (burst_start) begin
          state_d = ST_BURST;
        end else if (boundary && !pick_valid) begin
          state_d = ST_PARK;
        end
      end
      ST_BURST: begin
        // An owner dropping its request always drives IDLE, so that exit is
        // covered by the accepted-IDLE case; nothing moves while HREADY is low.
        if (i_HREADY && ((o_HTRANS == HTRANS_IDLE) ||
                         (nonseq_acc && (o_HBURST == HBURST_SINGLE)))) begin
          state_d = ST_OWN;
        end
      end
      default: begin
        state_d = ST_PARK;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_PARK;
      r_own_q    <= PARK_IDX;
      r_down_q   <= PARK_IDX;
      r_last_q   <= LAST_RST;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      r_own_q    <= r_own_d;
      r_down_q   <= r_down_d;
      r_last_q   <= r_last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - scoreboard bench for ahb_bus_arbiter against a rule-level model
module tb_ahb_bus_arbiter;
  import ahb_bus_arbiter_pkg::*;

  localparam int N    = 3;
  localparam int PARK = 2;
  localparam int MAXH = 4;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  logic               s_req   [N];
  logic [1:0]         s_trans [N];
  logic [31:0]        s_addr  [N];
  logic [31:0]        s_wdata [N];
  logic               s_wr    [N];
  logic [2:0]         s_size  [N];
  logic [W_BURST-1:0] s_burst [N];

  logic [N-1:0]         i_HBUSREQ;
  logic [N*32-1:0]      i_HADDR;
  logic [N*2-1:0]       i_HTRANS;
  logic [N-1:0]         i_HWRITE;
  logic [N*3-1:0]       i_HSIZE;
  logic [N*W_BURST-1:0] i_HBURST;
  logic [N*32-1:0]      i_HWDATA;
  logic [31:0]          i_HRDATA;
  logic [1:0]           i_HRESP;
  logic                 i_HREADY;

  logic [N-1:0]       o_HGRANT;
  logic [1:0]         o_HMASTER;
  logic [31:0]        o_HADDR;
  logic [1:0]         o_HTRANS;
  logic               o_HWRITE;
  logic [2:0]         o_HSIZE;
  logic [W_BURST-1:0] o_HBURST;
  logic [31:0]        o_HWDATA;
  logic [31:0]        o_HRDATA;
  logic [1:0]         o_HRESP;
  logic               o_HREADY;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign i_HBUSREQ[g]                  = s_req[g];
    assign i_HADDR[32*g +: 32]           = s_addr[g];
    assign i_HTRANS[2*g +: 2]            = s_trans[g];
    assign i_HWRITE[g]                   = s_wr[g];
    assign i_HSIZE[3*g +: 3]             = s_size[g];
    assign i_HBURST[W_BURST*g +: W_BURST] = s_burst[g];
    assign i_HWDATA[32*g +: 32]          = s_wdata[g];
  end

  ahb_bus_arbiter #(
    .N_MST    (N),
    .PARK_MST (PARK),
    .MAX_HOLD (MAXH)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .i_HBUSREQ (i_HBUSREQ),
    .i_HADDR   (i_HADDR),
    .i_HTRANS  (i_HTRANS),
    .i_HWRITE  (i_HWRITE),
    .i_HSIZE   (i_HSIZE),
    .i_HBURST  (i_HBURST),
    .i_HWDATA  (i_HWDATA),
    .o_HGRANT  (o_HGRANT),
    .o_HMASTER (o_HMASTER),
    .o_HADDR   (o_HADDR),
    .o_HTRANS  (o_HTRANS),
    .o_HWRITE  (o_HWRITE),
    .o_HSIZE   (o_HSIZE),
    .o_HBURST  (o_HBURST),
    .o_HWDATA  (o_HWDATA),
    .i_HRDATA  (i_HRDATA),
    .i_HRESP   (i_HRESP),
    .i_HREADY  (i_HREADY),
    .o_HRDATA  (o_HRDATA),
    .o_HRESP   (o_HRESP),
    .o_HREADY  (o_HREADY)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, who owns the data phase, who won
  // last, how many NONSEQs the owner has issued, whether a burst holds the
  // bus locked, and whether the bus is parked on an idle master.
  int m_own, m_down, m_last, m_hold;
  bit m_locked, m_parked, m_valid = 1'b0;

  task automatic model_edge();
    logic [1:0] tr;
    bit ns, others;
    int win, nxt, cand;
    if (HRESET) begin
      m_own = PARK; m_down = PARK; m_last = N - 1; m_hold = 0;
      m_locked = 1'b0; m_parked = 1'b1; m_valid = 1'b1;
      return;
    end
    if (!m_valid || !i_HREADY) return;
    tr = m_parked ? 2'b00 : s_trans[m_own];
    ns = (tr == 2'b10);
    m_down = m_own;
    if (m_locked) begin
      if (tr == 2'b00 || (ns && s_burst[m_own] == 0)) m_locked = 1'b0;
      if (ns && m_hold < 255) m_hold++;
    end else if (ns && s_burst[m_own] != 0) begin
      m_locked = 1'b1;
      if (m_hold < 255) m_hold++;
    end else begin
      others = 1'b0;
      for (int m = 0; m < N; m++) if (m != m_own && s_req[m]) others = 1'b1;
      win = -1;
      for (int k = 1; k <= N; k++) begin
        cand = (m_last + k) % N;
        if (win < 0 && s_req[cand] && !(cand == m_own && m_hold >= MAXH && others)) win = cand;
      end
      if (win < 0) begin
        nxt = PARK; m_parked = 1'b1;
      end else begin
        nxt = win; m_last = win; m_parked = 1'b0;
      end
      if (nxt != m_own) m_hold = 0;
      else if (ns && m_hold < 255) m_hold++;
      m_own = nxt;
    end
  endtask

  typedef struct {
    logic [N-1:0]       grant;
    logic [1:0]         master;
    logic [1:0]         trans;
    logic [31:0]        addr;
    logic               wr;
    logic [2:0]         size;
    logic [W_BURST-1:0] burst;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic [1:0]         resp;
    logic               ready;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic expect_now();
    exp_t e;
    if (!m_valid) return;
    e.grant         = '0;
    e.grant[m_own]  = 1'b1;
    e.master        = 2'(m_own);
    e.trans         = m_parked ? 2'b00 : s_trans[m_own];
    e.addr          = s_addr[m_own];
    e.wr            = s_wr[m_own];
    e.size          = s_size[m_own];
    e.burst         = s_burst[m_own];
    e.wdata         = s_wdata[m_down];
    e.rdata         = i_HRDATA;
    e.resp          = i_HRESP;
    e.ready         = i_HREADY;
    exp_q.push_back(e);
  endtask

  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("grant",  32'(o_HGRANT),  32'(mon_e.grant));
      chk("master", 32'(o_HMASTER), 32'(mon_e.master));
      chk("htrans", 32'(o_HTRANS),  32'(mon_e.trans));
      chk("haddr",  o_HADDR,        mon_e.addr);
      chk("hwrite", 32'(o_HWRITE),  32'(mon_e.wr));
      chk("hsize",  32'(o_HSIZE),   32'(mon_e.size));
      chk("hburst", 32'(o_HBURST),  32'(mon_e.burst));
      chk("hwdata", o_HWDATA,       mon_e.wdata);
      chk("hrdata", o_HRDATA,       mon_e.rdata);
      chk("hresp",  32'(o_HRESP),   32'(mon_e.resp));
      chk("hready", 32'(o_HREADY),  32'(mon_e.ready));
    end
  end

  // One bus cycle: record what the current inputs should produce, then
  // let the clock edge consume them.
  task automatic cyc();
    expect_now();
    @(posedge HCLK);
    model_edge();
    #1;
  endtask

  task automatic rand_inputs(input int req_pct, input int rdy_pct, input int rst_pm);
    int r;
    for (int m = 0; m < N; m++) begin
      s_req[m]   = ($urandom_range(0, 99) < req_pct);
      r          = $urandom_range(0, 9);
      s_trans[m] = (r < 3) ? 2'b00 : (r == 3) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
      s_burst[m] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      s_addr[m]  = $urandom;
      s_wdata[m] = $urandom;
      s_wr[m]    = 1'($urandom_range(0, 1));
      s_size[m]  = 3'($urandom_range(0, 2));
    end
    i_HREADY = ($urandom_range(0, 99) < rdy_pct);
    i_HRDATA = $urandom;
    i_HRESP  = 2'($urandom_range(0, 3));
    HRESET   = ($urandom_range(0, 999) < rst_pm);
  endtask

  initial begin
    HRESET   = 1'b1;
    i_HREADY = 1'b1;
    i_HRDATA = 32'h1234_5678;
    i_HRESP  = 2'b00;
    for (int m = 0; m < N; m++) begin
      s_req[m] = 1'b0; s_trans[m] = 2'b00; s_burst[m] = '0;
      s_addr[m] = 32'h4000_0000 + 32'(m) * 32'h100;
      s_wdata[m] = 32'hD000_0000 + 32'(m);
      s_wr[m] = 1'b1; s_size[m] = 3'd2;
    end
    s_trans[PARK] = 2'b10;
    cyc();
    cyc();
    chk("rst_grant",  32'(o_HGRANT),  32'd1 << PARK);
    chk("rst_master", 32'(o_HMASTER), 32'(PARK));
    chk("rst_htrans", 32'(o_HTRANS),  32'd0);

    // Two simultaneous requesters: master 0 first, master 1 after one single.
    HRESET = 1'b0;
    s_trans[PARK] = 2'b00;
    s_req[0] = 1'b1; s_req[1] = 1'b1;
    s_trans[0] = 2'b10; s_burst[0] = 3'd0;
    cyc();
    chk("first_grant", 32'(o_HGRANT), 32'b001);
    cyc();
    chk("rr_grant",  32'(o_HGRANT),  32'b010);
    chk("rr_master", 32'(o_HMASTER), 32'd1);

    // Master 1 starts INCR4 while master 0 keeps requesting.
    s_trans[0] = 2'b00;
    s_trans[1] = 2'b10; s_burst[1] = 3'd3;
    cyc();
    chk("burst_hold1", 32'(o_HGRANT), 32'b010);
    s_trans[1] = 2'b11;
    cyc();
    chk("burst_hold2", 32'(o_HGRANT), 32'b010);

    // Reset in the middle of the burst.
    s_trans[PARK] = 2'b10;
    HRESET = 1'b1;
    cyc();
    chk("midrst_grant",  32'(o_HGRANT),  32'd1 << PARK);
    chk("midrst_master", 32'(o_HMASTER), 32'(PARK));
    chk("midrst_htrans", 32'(o_HTRANS),  32'd0);
    HRESET = 1'b0;
    for (int m = 0; m < N; m++) s_req[m] = 1'b0;
    cyc();
    chk("park_grant",  32'(o_HGRANT), 32'd1 << PARK);
    chk("park_htrans", 32'(o_HTRANS), 32'd0);

    // Randomized phases: balanced, slave stalls, dense contention.
    for (int i = 0; i < 1200; i++) begin rand_inputs(50, 80, 5);  cyc(); end
    for (int i = 0; i < 800;  i++) begin rand_inputs(60, 35, 3);  cyc(); end
    for (int i = 0; i < 1200; i++) begin rand_inputs(90, 90, 2);  cyc(); end
    for (int i = 0; i < 400;  i++) begin rand_inputs(15, 70, 10); cyc(); end

    @(negedge HCLK);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
